// File: rtl/axis_frame_arbiter_if.sv
// Bundled source-side and sink-side FWFT stream signals of the frame arbiter.
// master: arbiter side; slave: the surrounding sources/consumer.
interface axis_frame_arbiter_if #(
  parameter int N    = 8,
  parameter int NSRC = 4
);
  localparam int TW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]   s_tvalid;
  logic [NSRC*N-1:0] s_tdata;
  logic [NSRC-1:0]   s_tfirst;
  logic [NSRC-1:0]   s_tnext;
  logic              m_tvalid;
  logic [N-1:0]      m_tdata;
  logic              m_tfirst;
  logic              m_tnext;
  logic [TW-1:0]     m_tid;

  modport master (
    input  s_tvalid, s_tdata, s_tfirst, m_tnext,
    output s_tnext, m_tvalid, m_tdata, m_tfirst, m_tid
  );

  modport slave (
    output s_tvalid, s_tdata, s_tfirst, m_tnext,
    input  s_tnext, m_tvalid, m_tdata, m_tfirst, m_tid
  );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter from NSRC FWFT sources onto one FWFT consumer.
// Zero-latency forwarding while granted, 1-cycle arbitration; orphan heads are drained and counted.
module axis_frame_arbiter #(
  parameter int N      = 8,
  parameter int NSRC   = 4,
  parameter int W_DROP = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  axis_frame_arbiter_if.master bus,
  output logic                 busy,
  output logic [W_DROP-1:0]    drop_count
);
  localparam int TW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int SW = W_DROP + 5;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [SW-1:0] DROP_MAX = {{(SW-W_DROP){1'b0}}, {W_DROP{1'b1}}};

  logic [0:0]      state;
  logic            started;
  logic [TW-1:0]   grant;
  logic [TW-1:0]   last_grant;
  logic [TW-1:0]   rr_idx;
  logic            rr_found;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] own;
  logic [NSRC-1:0] drain;
  logic            g_vld;
  logic            g_first;
  logic [N-1:0]    g_dat;
  logic            m_vld;
  logic            frame_end;
  logic [SW-1:0]   drop_sum;
  logic [SW-1:0]   drop_next;

  assign req = bus.s_tvalid & bus.s_tfirst;

  // First requester in round-robin order starting just after the last grant.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = (int'(last_grant) + k) % NSRC;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = TW'(idx);
      end
    end
  end

  always_comb begin
    busy      = (state == BUSY);
    g_vld     = bus.s_tvalid[grant];
    g_first   = bus.s_tfirst[grant];
    g_dat     = bus.s_tdata[grant*N +: N];
    m_vld     = busy & g_vld & (~g_first | ~started);
    frame_end = busy & started & g_vld & g_first;
    own       = '0;
    if (busy) own[grant] = 1'b1;
    // Held off while reset is asserted so every output is quiet during reset.
    drain     = bus.s_tvalid & ~bus.s_tfirst & ~own & {NSRC{rst}};
    drop_sum  = '0;
    for (int i = 0; i < NSRC; i++) drop_sum = drop_sum + SW'(drain[i]);
    drop_next = {{(SW-W_DROP){1'b0}}, drop_count} + drop_sum;
  end

  assign bus.m_tvalid = m_vld;
  assign bus.m_tdata  = busy ? g_dat : '0;
  assign bus.m_tfirst = busy & g_first & ~started;
  assign bus.s_tnext  = drain | ((m_vld & bus.m_tnext) ? own : '0);
  assign bus.m_tid    = grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      started    <= 1'b0;
      grant      <= '0;
      last_grant <= TW'(NSRC - 1);
    end else begin
      case (state)
        IDLE: begin
          if (arb_en && rr_found) begin
            grant   <= rr_idx;
            started <= 1'b0;
            state   <= BUSY;
          end
        end
        default: begin
          if (frame_end) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (m_vld && bus.m_tnext) begin
            started <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (drop_next > DROP_MAX) begin
      drop_count <= {W_DROP{1'b1}};
    end else begin
      drop_count <= drop_next[W_DROP-1:0];
    end
  end
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench: four scripted FWFT sources, a consumer that accepts every valid word,
// and checks of grant order, frame boundaries, stalls, arb_en gating, orphan drain and reset.
module tb_axis_frame_arbiter;
  localparam int N    = 8;
  localparam int NSRC = 4;
  localparam int W_DROP = 16;

  logic clk;
  logic rst;
  logic arb_en;
  logic busy;
  logic [W_DROP-1:0] drop_count;
  logic flush;

  axis_frame_arbiter_if #(.N(N), .NSRC(NSRC)) bus ();

  axis_frame_arbiter #(.N(N), .NSRC(NSRC), .W_DROP(W_DROP)) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .bus        (bus),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source queues: {tfirst, data} per entry.
  logic [8:0] mem [NSRC][64];
  logic [5:0] wp [NSRC];
  logic [5:0] rp [NSRC];
  logic [NSRC-1:0]   sv;
  logic [NSRC*N-1:0] sd;
  logic [NSRC-1:0]   sf;

  always_comb begin
    sv = '0;
    sd = '0;
    sf = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (rp[i] != wp[i]) begin
        sv[i]         = 1'b1;
        sd[i*N +: N]  = mem[i][rp[i]][7:0];
        sf[i]         = mem[i][rp[i]][8];
      end
    end
  end

  assign bus.s_tvalid = sv;
  assign bus.s_tdata  = sd;
  assign bus.s_tfirst = sf;
  assign bus.m_tnext  = bus.m_tvalid;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (flush) rp[i] <= wp[i];
      else if (bus.s_tnext[i]) rp[i] <= rp[i] + 6'd1;
    end
  end

  // Capture of accepted output words.
  logic [7:0] od [64];
  logic       of [64];
  logic [1:0] ot [64];
  int         oc [64];
  int         out_cnt;
  int         cyc;
  int         dcnt2;

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      out_cnt <= 0;
      dcnt2   <= 0;
    end else begin
      if (bus.m_tvalid && bus.m_tnext) begin
        od[out_cnt] <= bus.m_tdata;
        of[out_cnt] <= bus.m_tfirst;
        ot[out_cnt] <= bus.m_tid;
        oc[out_cnt] <= cyc;
        out_cnt     <= out_cnt + 1;
      end
      if (bus.s_tnext[2]) dcnt2 <= dcnt2 + 1;
    end
  end

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int src, input logic tf, input logic [7:0] d);
    mem[src][wp[src]] = {tf, d};
    wp[src] = wp[src] + 6'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic wait_out(input int n, input string tag);
    int t;
    t = 0;
    while (out_cnt < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, out_cnt, n);
  endtask

  initial begin
    int bad;
    checks = 0;
    errors = 0;
    cyc = 0;
    out_cnt = 0;
    dcnt2 = 0;
    for (int i = 0; i < NSRC; i++) begin
      wp[i] = '0;
      rp[i] = '0;
    end
    rst = 1'b0;
    flush = 1'b1;
    arb_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", bus.m_tvalid, 0);
    chk("rst_snext", bus.s_tnext, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_tid", bus.m_tid, 0);

    // Single frame with cycle-exact timing
    do_reset();
    push(0, 1'b1, 8'h11);
    push(0, 1'b0, 8'h22);
    push(0, 1'b0, 8'h33);
    push(0, 1'b1, 8'h44);
    #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_mvalid", bus.m_tvalid, 0);
    @(negedge clk);
    chk("t1_g_busy", busy, 1);
    chk("t1_g_mvalid", bus.m_tvalid, 1);
    chk("t1_w0_data", bus.m_tdata, 8'h11);
    chk("t1_w0_first", bus.m_tfirst, 1);
    chk("t1_g_tid", bus.m_tid, 0);
    @(negedge clk);
    chk("t1_w1_data", bus.m_tdata, 8'h22);
    chk("t1_w1_first", bus.m_tfirst, 0);
    @(negedge clk);
    chk("t1_w2_data", bus.m_tdata, 8'h33);
    @(negedge clk);
    chk("t1_end_mvalid", bus.m_tvalid, 0);
    chk("t1_end_busy", busy, 1);
    chk("t1_end_snext", bus.s_tnext, 0);
    @(negedge clk);
    chk("t1_gap_busy", busy, 0);
    @(negedge clk);
    chk("t1_re_busy", busy, 1);
    chk("t1_re_data", bus.m_tdata, 8'h44);
    chk("t1_re_first", bus.m_tfirst, 1);
    chk("t1_cnt", out_cnt, 3);

    // Round-robin over four simultaneous 2-word frames
    do_reset();
    for (int s = 0; s < NSRC; s++) begin
      push(s, 1'b1, 8'(s*16));
      push(s, 1'b0, 8'(s*16 + 1));
      push(s, 1'b1, 8'(s*16 + 2));
    end
    wait_out(9, "t2_cnt");
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_data%0d", k), od[k], 8'((k/2)*16 + (k%2)));
      chk($sformatf("t2_first%0d", k), of[k], (k%2 == 0) ? 1 : 0);
      chk($sformatf("t2_tid%0d", k), ot[k], k/2);
    end
    chk("t2_data8", od[8], 8'h02);
    chk("t2_tid8", ot[8], 0);
    chk("t2_contig", oc[1] - oc[0], 1);
    chk("t2_gap", oc[2] - oc[1], 3);

    // Orphan drain alongside a granted stream
    do_reset();
    push(0, 1'b1, 8'h01);
    push(0, 1'b0, 8'h02);
    push(0, 1'b0, 8'h03);
    push(2, 1'b0, 8'hc1);
    push(2, 1'b0, 8'hc2);
    push(2, 1'b0, 8'hc3);
    #1;
    chk("t3_drain_now", bus.s_tnext, 4'b0100);
    repeat (8) @(negedge clk);
    chk("t3_drop", drop_count, 3);
    chk("t3_pulses", dcnt2, 3);
    chk("t3_cnt", out_cnt, 3);
    chk("t3_d0", od[0], 8'h01);
    chk("t3_f0", of[0], 1);
    chk("t3_d2", od[2], 8'h03);

    // Stall of the granted source while another requests
    do_reset();
    push(0, 1'b1, 8'h41);
    push(0, 1'b0, 8'h42);
    push(1, 1'b1, 8'h51);
    push(1, 1'b0, 8'h52);
    push(1, 1'b1, 8'h53);
    wait_out(2, "t4_pre");
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && bus.m_tvalid === 1'b0 && bus.m_tid === 2'd0)) bad++;
    end
    chk("t4_hold", bad, 0);
    push(0, 1'b0, 8'h43);
    push(0, 1'b1, 8'h44);
    wait_out(6, "t4_cnt");
    chk("t4_resume_data", od[2], 8'h43);
    chk("t4_resume_first", of[2], 0);
    chk("t4_resume_tid", ot[2], 0);
    chk("t4_next_data", od[3], 8'h51);
    chk("t4_next_tid", ot[3], 1);
    chk("t4_last_data", od[5], 8'h44);

    // arb_en dropped mid-frame
    do_reset();
    push(0, 1'b1, 8'h61);
    push(0, 1'b0, 8'h62);
    push(0, 1'b1, 8'h63);
    push(1, 1'b1, 8'h71);
    push(1, 1'b0, 8'h72);
    @(negedge clk);
    chk("t5_busy", busy, 1);
    arb_en = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_parked", busy, 0);
    chk("t5_cnt", out_cnt, 2);
    chk("t5_mvalid", bus.m_tvalid, 0);
    arb_en = 1'b1;
    @(negedge clk);
    chk("t5_regrant", busy, 1);
    chk("t5_tid", bus.m_tid, 1);

    // Reset mid-frame: leftover words become orphans
    do_reset();
    push(3, 1'b1, 8'h81);
    push(3, 1'b0, 8'h82);
    push(3, 1'b0, 8'h83);
    push(3, 1'b0, 8'h84);
    wait_out(2, "t6_pre");
    chk("t6_pre_tid", bus.m_tid, 3);
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mvalid", bus.m_tvalid, 0);
    chk("t6_mdata", bus.m_tdata, 0);
    chk("t6_mfirst", bus.m_tfirst, 0);
    chk("t6_tid", bus.m_tid, 0);
    chk("t6_snext", bus.s_tnext, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_drop", drop_count, 2);
    chk("t6_empty", bus.s_tvalid[3], 0);
    chk("t6_cnt", out_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
